exe_stage: RTL



---
 rtl/exe_stage_pkg.sv | 51 +++++
 rtl/exe_stage_if.sv | 26 ++
 rtl/exe_stage_alu.sv | 54 +++++
 rtl/exe_stage.sv | 126 ++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage.
// Holds the bus widths, the field layout of the decode->execute and
// execute->memory buses as packed structs (MSB first), and the ALU opcode
// bit indices. The ALU opcode is one-hot.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 137;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ALU_OP_WD       = 12;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam logic [1:0] SRAM_SIZE_WORD = 2'd2;

  typedef struct packed {
    logic                 src2_is_zero;
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 load_op;
    logic                 src1_is_sa;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 src2_is_8;
    logic                 gr_we;
    logic                 mem_we;
    logic [4:0]           dest;
    logic [15:0]          imm;
    logic [31:0]          rs_value;
    logic [31:0]          rt_value;
    logic [31:0]          pc;
  } ds_to_es_t;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

endpackage

// File: rtl/exe_stage_if.sv
// Data-SRAM request interface (req/addr_ok handshake).
// master (execute stage): drives req, wr, size, wstrb, addr, wdata;
//                         receives addr_ok.
// slave  (memory side):   the reverse.
// A request is accepted in any cycle where req and addr_ok are both high.
interface exe_stage_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok
  );

endinterface

// File: rtl/exe_stage_alu.sv
// Combinational ALU shared by the execute stage.
// Ports: alu_op (one-hot opcode, bit indices in exe_stage_pkg),
//        alu_src1, alu_src2 (operands), alu_result (result).
// Shifts take the amount from alu_src1[4:0] and shift alu_src2.
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [ALU_OP_WD-1:0] alu_op,
  input  logic [31:0]          alu_src1,
  input  logic [31:0]          alu_src2,
  output logic [31:0]          alu_result
);

  logic        use_sub;
  logic [31:0] adder_b;
  logic [31:0] adder_result;
  logic        adder_cout;
  logic        slt_result;
  logic        sltu_result;
  logic [31:0] sll_result;
  logic [31:0] srl_result;
  logic [31:0] sra_result;

  // One adder serves add, sub and both compares: a - b = a + ~b + 1.
  assign use_sub = alu_op[ALU_SUB] | alu_op[ALU_SLT] | alu_op[ALU_SLTU];
  assign adder_b = use_sub ? ~alu_src2 : alu_src2;
  assign {adder_cout, adder_result} = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, use_sub};

  // Signed less-than: operands of opposite sign decide directly, else the
  // sign of the difference. Unsigned: a borrow means no carry out.
  assign slt_result  = (alu_src1[31] & ~alu_src2[31])
                     | (~(alu_src1[31] ^ alu_src2[31]) & adder_result[31]);
  assign sltu_result = ~adder_cout;

  assign sll_result = alu_src2 << alu_src1[4:0];
  assign srl_result = alu_src2 >> alu_src1[4:0];
  assign sra_result = $signed(alu_src2) >>> alu_src1[4:0];

  always_comb begin
    alu_result = 32'd0;
    if (alu_op[ALU_ADD] | alu_op[ALU_SUB]) alu_result = alu_result | adder_result;
    if (alu_op[ALU_SLT])  alu_result = alu_result | {31'd0, slt_result};
    if (alu_op[ALU_SLTU]) alu_result = alu_result | {31'd0, sltu_result};
    if (alu_op[ALU_AND])  alu_result = alu_result | (alu_src1 & alu_src2);
    if (alu_op[ALU_NOR])  alu_result = alu_result | ~(alu_src1 | alu_src2);
    if (alu_op[ALU_OR])   alu_result = alu_result | (alu_src1 | alu_src2);
    if (alu_op[ALU_XOR])  alu_result = alu_result | (alu_src1 ^ alu_src2);
    if (alu_op[ALU_SLL])  alu_result = alu_result | sll_result;
    if (alu_op[ALU_SRL])  alu_result = alu_result | srl_result;
    if (alu_op[ALU_SRA])  alu_result = alu_result | sra_result;
    if (alu_op[ALU_LUI])  alu_result = alu_result | {alu_src2[15:0], 16'd0};
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// Registers the decode bus, selects ALU operands, computes the result and
// issues lw/sw requests on the data-SRAM interface.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   ms_allowin         memory stage can accept
//   es_allowin         this stage can accept
//   ds_to_es_valid/bus decode -> execute bus
//   es_to_ms_valid/bus execute -> memory bus
//   es_load_op         valid load in this stage (load-use stall)
//   es_to_ds_result    ALU result (bypass)
//   ES_dest            bypass destination, 0 when nothing is written
//   data_sram          request interface (master side)
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       es_load_op,
  output logic [31:0]                es_to_ds_result,
  output logic [4:0]                 ES_dest,
  exe_stage_if.master                data_sram
);

  ds_to_es_t   ds_r;
  es_to_ms_t   ms_bus;
  logic        es_valid;
  logic        addr_acked;
  logic        mem_op;
  logic        fire;
  logic        es_ready_go;
  logic        leaving;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] alu_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
    end else if (es_allowin) begin
      es_valid <= ds_to_es_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ds_to_es_valid && es_allowin) begin
      ds_r <= ds_to_es_t'(ds_to_es_bus);
    end
  end

  // addr_acked remembers an accepted request while the instruction is held
  // by the memory stage, so the request is never reissued. If the request
  // is accepted in the same cycle the instruction leaves, the flag stays
  // clear and the next instruction starts clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_acked <= 1'b0;
    end else if (leaving) begin
      addr_acked <= 1'b0;
    end else if (fire) begin
      addr_acked <= 1'b1;
    end
  end

  assign mem_op      = ds_r.load_op | ds_r.mem_we;
  assign fire        = data_sram.req && data_sram.addr_ok;
  assign es_ready_go = !mem_op || fire || addr_acked;

  assign es_to_ms_valid = es_valid && es_ready_go;
  assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
  assign leaving        = es_to_ms_valid && ms_allowin;

  always_comb begin
    src1 = ds_r.rs_value;
    if (ds_r.src1_is_sa) begin
      src1 = {27'd0, ds_r.imm[10:6]};
    end else if (ds_r.src1_is_pc) begin
      src1 = ds_r.pc;
    end
  end

  always_comb begin
    src2 = ds_r.rt_value;
    if (ds_r.src2_is_imm) begin
      src2 = ds_r.src2_is_zero ? {16'd0, ds_r.imm} : {{16{ds_r.imm[15]}}, ds_r.imm};
    end else if (ds_r.src2_is_8) begin
      src2 = 32'd8;
    end
  end

  exe_stage_alu u_alu (
    .alu_op     (ds_r.alu_op),
    .alu_src1   (src1),
    .alu_src2   (src2),
    .alu_result (alu_result)
  );

  always_comb begin
    ms_bus.res_from_mem = ds_r.load_op;
    ms_bus.gr_we        = ds_r.gr_we;
    ms_bus.dest         = ds_r.dest;
    ms_bus.alu_result   = alu_result;
    ms_bus.pc           = ds_r.pc;
  end

  assign es_to_ms_bus    = ms_bus;
  assign es_to_ds_result = alu_result;
  assign ES_dest         = (es_valid && ds_r.gr_we) ? ds_r.dest : 5'd0;
  assign es_load_op      = es_valid && ds_r.load_op;

  // Request fields come straight from the bus register, which cannot load
  // while a request is pending, so they stay stable until addr_ok.
  assign data_sram.req   = es_valid && mem_op && !addr_acked;
  assign data_sram.wr    = ds_r.mem_we;
  assign data_sram.size  = SRAM_SIZE_WORD;
  assign data_sram.wstrb = ds_r.mem_we ? 4'hf : 4'h0;
  assign data_sram.addr  = alu_result;
  assign data_sram.wdata = ds_r.rt_value;

endmodule
